// File: rtl/knap_eval_seq.sv
// knap_eval_seq
//   Sequential knapsack evaluator. A per-item coefficient table
//   (value/weight/volume) is written through the cfg_* port while idle.
//   A selection vector is accepted over in_valid/in_ready. Selected items
//   are then accumulated one per cycle with saturating adds. The run exits
//   early once the weight or volume limit is exceeded. The totals and a
//   pass verdict are held on out_* until the result is taken with
//   out_valid/out_ready.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   cfg_we/cfg_idx/cfg_*        coefficient table write (idle only)
//   min_value/max_weight/max_volume  thresholds, latched on accept
//   in_valid/in_ready/in_sel    selection handshake
//   out_valid/out_ready         result handshake
//   out_pass/out_early          verdict, capacity-abort flag
//   out_value/out_weight/out_volume  totals
//
// state | meaning
// IDLE  | ready for a selection; coefficient writes allowed
// ACCUM | walking items 0..N_ITEMS-1, one per cycle
// DONE  | result presented until out_ready
module knap_eval_seq #(
  parameter int N_ITEMS = 26,
  parameter int COEF_W  = 5,
  parameter int ACC_W   = 12,
  parameter int IDX_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [COEF_W-1:0]  cfg_value,
  input  logic [COEF_W-1:0]  cfg_weight,
  input  logic [COEF_W-1:0]  cfg_volume,
  input  logic [ACC_W-1:0]   min_value,
  input  logic [ACC_W-1:0]   max_weight,
  input  logic [ACC_W-1:0]   max_volume,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_ITEMS-1:0] in_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_pass,
  output logic               out_early,
  output logic [ACC_W-1:0]   out_value,
  output logic [ACC_W-1:0]   out_weight,
  output logic [ACC_W-1:0]   out_volume
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_ITEMS - 1);
  localparam logic [IDX_W:0]   ITEMS_EXT = (IDX_W + 1)'(N_ITEMS);

  state_t state, state_next;

  logic [IDX_W-1:0]   idx;
  logic [N_ITEMS-1:0] sel;
  logic [ACC_W-1:0]   thr_min, thr_weight, thr_volume;
  logic [ACC_W-1:0]   acc_value, acc_weight, acc_volume;
  logic               early;

  logic [COEF_W-1:0] tab_value  [N_ITEMS];
  logic [COEF_W-1:0] tab_weight [N_ITEMS];
  logic [COEF_W-1:0] tab_volume [N_ITEMS];

  logic             accept, item_on, over, last, cfg_ok;
  logic [ACC_W-1:0] sum_value, sum_weight, sum_volume;

  // One extra bit catches the carry; any carry clamps to all-ones.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [COEF_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W + 1)'(b);
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

  always_comb begin
    item_on    = sel[idx];
    sum_value  = item_on ? sat_add(acc_value,  tab_value[idx])  : acc_value;
    sum_weight = item_on ? sat_add(acc_weight, tab_weight[idx]) : acc_weight;
    sum_volume = item_on ? sat_add(acc_volume, tab_volume[idx]) : acc_volume;
    over       = (sum_weight > thr_weight) || (sum_volume > thr_volume);
    last       = (idx == LAST_IDX);
    accept     = (state == IDLE) && in_valid;
    cfg_ok     = (state == IDLE) && cfg_we && ({1'b0, cfg_idx} < ITEMS_EXT);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ACCUM;
      end
      ACCUM: begin
        if (over || last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      sel        <= '0;
      thr_min    <= '0;
      thr_weight <= '0;
      thr_volume <= '0;
      acc_value  <= '0;
      acc_weight <= '0;
      acc_volume <= '0;
      early      <= 1'b0;
      for (int i = 0; i < N_ITEMS; i++) begin
        tab_value[i]  <= '0;
        tab_weight[i] <= '0;
        tab_volume[i] <= '0;
      end
    end else begin
      // A write in the accept cycle lands before item 0 is read.
      if (cfg_ok) begin
        tab_value[cfg_idx]  <= cfg_value;
        tab_weight[cfg_idx] <= cfg_weight;
        tab_volume[cfg_idx] <= cfg_volume;
      end
      if (accept) begin
        sel        <= in_sel;
        thr_min    <= min_value;
        thr_weight <= max_weight;
        thr_volume <= max_volume;
        acc_value  <= '0;
        acc_weight <= '0;
        acc_volume <= '0;
        early      <= 1'b0;
        idx        <= '0;
      end
      if (state == ACCUM) begin
        acc_value  <= sum_value;
        acc_weight <= sum_weight;
        acc_volume <= sum_volume;
        if (over)       early <= 1'b1;
        else if (!last) idx   <= idx + 1'b1;
      end
    end
  end

  // Gated by DONE so the all-zero reset state does not read as a pass.
  always_comb begin
    out_pass   = (state == DONE) && (acc_value >= thr_min) &&
                 (acc_weight <= thr_weight) && (acc_volume <= thr_volume);
    out_early  = early;
    out_value  = acc_value;
    out_weight = acc_weight;
    out_volume = acc_volume;
  end

endmodule

// File: tb/tb_knap_eval_seq.sv
module tb_knap_eval_seq;
  localparam int N = 26, CW = 5, AW = 12, IW = 5;
  localparam int SN = 4, SAW = 6, SIW = 2;

  localparam logic [N-1:0] SEL_DKSZ = 26'h2040408;
  localparam logic [N-1:0] SEL_ACEF = 26'h0000035;
  localparam logic [N-1:0] SEL_Z    = 26'h2000000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [CW-1:0] cfg_value, cfg_weight, cfg_volume;
  logic [AW-1:0] min_value, max_weight, max_volume;
  logic          in_valid, in_ready, out_valid, out_ready, out_pass, out_early;
  logic [N-1:0]  in_sel;
  logic [AW-1:0] out_value, out_weight, out_volume;

  logic           s_cfg_we;
  logic [SIW-1:0] s_cfg_idx;
  logic [CW-1:0]  s_cfg_value, s_cfg_weight, s_cfg_volume;
  logic [SAW-1:0] s_min_value, s_max_weight, s_max_volume;
  logic           s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_pass, s_out_early;
  logic [SN-1:0]  s_in_sel;
  logic [SAW-1:0] s_out_value, s_out_weight, s_out_volume;

  knap_eval_seq #(.N_ITEMS(N), .COEF_W(CW), .ACC_W(AW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_value(cfg_value), .cfg_weight(cfg_weight), .cfg_volume(cfg_volume),
    .min_value(min_value), .max_weight(max_weight), .max_volume(max_volume),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_pass(out_pass),
    .out_early(out_early), .out_value(out_value), .out_weight(out_weight),
    .out_volume(out_volume));

  knap_eval_seq #(.N_ITEMS(SN), .COEF_W(CW), .ACC_W(SAW), .IDX_W(SIW)) dut_s (
    .clk(clk), .rst(rst), .cfg_we(s_cfg_we), .cfg_idx(s_cfg_idx),
    .cfg_value(s_cfg_value), .cfg_weight(s_cfg_weight), .cfg_volume(s_cfg_volume),
    .min_value(s_min_value), .max_weight(s_max_weight), .max_volume(s_max_volume),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_sel(s_in_sel),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_pass(s_out_pass),
    .out_early(s_out_early), .out_value(s_out_value), .out_weight(s_out_weight),
    .out_volume(s_out_volume));

  typedef struct {
    logic [N-1:0]  sel;
    logic [AW-1:0] minv, maxw, maxv;
    int            lat;
    logic [AW-1:0] val, wt, vol;
    logic          pass, early;
  } vec_t;

  int checks = 0;
  int failures = 0;

  logic [CW-1:0] tv [N];
  logic [CW-1:0] tw [N];
  logic [CW-1:0] tl [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input int i, input logic [CW-1:0] v, w, l);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = IW'(i); cfg_value = v; cfg_weight = w; cfg_volume = l;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Offers a selection and returns just after the accept edge; inputs are
  // then scrambled so any late sampling would corrupt the result.
  task automatic start(input vec_t v, input string tag, input logic cfg_acc,
                       input int ci, input logic [CW-1:0] cv, cw, cl);
    @(negedge clk);
    in_sel = v.sel; min_value = v.minv; max_weight = v.maxw; max_volume = v.maxv;
    in_valid = 1'b1;
    if (cfg_acc) begin
      cfg_we = 1'b1; cfg_idx = IW'(ci); cfg_value = cv; cfg_weight = cw; cfg_volume = cl;
    end
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
    in_sel = '1; min_value = '0; max_weight = '1; max_volume = '1;
  endtask

  task automatic wait_done(input int from, output int cyc);
    cyc = from;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic check_result(input vec_t v, input string tag, input int cyc);
    check({tag, "_latency"}, 64'(cyc), 64'(v.lat));
    check({tag, "_in_ready_busy"}, 64'(in_ready), 64'(0));
    check({tag, "_value"}, 64'(out_value), 64'(v.val));
    check({tag, "_weight"}, 64'(out_weight), 64'(v.wt));
    check({tag, "_volume"}, 64'(out_volume), 64'(v.vol));
    check({tag, "_pass"}, 64'(out_pass), 64'(v.pass));
    check({tag, "_early"}, 64'(out_early), 64'(v.early));
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_back_idle"}, 64'({out_valid, in_ready}), 64'(2'b01));
  endtask

  task automatic run(input vec_t v, input string tag, input logic cfg_acc,
                     input int ci, input logic [CW-1:0] cv, cw, cl);
    int cyc;
    start(v, tag, cfg_acc, ci, cv, cw, cl);
    wait_done(0, cyc);
    check_result(v, tag, cyc);
    release_result(tag);
  endtask

  vec_t vecs [7];

  initial begin
    int cyc;
    vec_t v;
    logic [39:0] hold_exp;

    for (int i = 0; i < N; i++) begin
      tv[i] = CW'(i % 7 + 1);
      tw[i] = CW'(i % 5 + 1);
      tl[i] = CW'(i % 3 + 1);
    end
    tv[0]  = 4;  tw[0]  = 28; tl[0]  = 27;
    tv[2]  = 5;  tw[2]  = 27; tl[2]  = 10;
    tv[3]  = 25; tw[3]  = 8;  tl[3]  = 12;
    tv[4]  = 6;  tw[4]  = 27; tl[4]  = 10;
    tv[5]  = 7;  tw[5]  = 28; tl[5]  = 10;
    tv[10] = 27; tw[10] = 8;  tl[10] = 12;
    tv[18] = 27; tw[18] = 8;  tl[18] = 13;
    tv[25] = 30; tw[25] = 13; tl[25] = 22;

    //           sel       min  maxw maxv lat  val  wt   vol  pass early
    vecs[0] = '{SEL_DKSZ, 100, 100, 100, 26, 109, 37,  59,  1'b1, 1'b0};
    vecs[1] = '{SEL_ACEF, 0,   100, 100, 6,  22,  110, 57,  1'b0, 1'b1};
    vecs[2] = '{SEL_DKSZ, 180, 100, 100, 26, 109, 37,  59,  1'b0, 1'b0};
    vecs[3] = '{SEL_DKSZ, 109, 37,  59,  26, 109, 37,  59,  1'b1, 1'b0};
    vecs[4] = '{SEL_DKSZ, 110, 100, 100, 26, 109, 37,  59,  1'b0, 1'b0};
    vecs[5] = '{SEL_Z,    0,   100, 21,  26, 30,  13,  22,  1'b0, 1'b1};
    vecs[6] = '{'0,       0,   0,   0,   26, 0,   0,   0,   1'b1, 1'b0};

    rst = 1'b1;
    cfg_we = 0; cfg_idx = 0; cfg_value = 0; cfg_weight = 0; cfg_volume = 0;
    min_value = 0; max_weight = 0; max_volume = 0;
    in_valid = 0; in_sel = 0; out_ready = 0;
    s_cfg_we = 0; s_cfg_idx = 0; s_cfg_value = 0; s_cfg_weight = 0; s_cfg_volume = 0;
    s_min_value = 0; s_max_weight = 0; s_max_volume = 0;
    s_in_valid = 0; s_in_sel = 0; s_out_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_handshake", 64'({in_ready, out_valid}), 64'(2'b10));
    check("reset_flags", 64'({out_pass, out_early}), 64'(2'b00));
    check("reset_totals", 64'({out_value, out_weight, out_volume}), 64'(0));

    for (int i = 0; i < N; i++) cfg_write(i, tv[i], tw[i], tl[i]);

    for (int i = 0; i < 7; i++)
      run(vecs[i], $sformatf("vec%0d", i), 1'b0, 0, 0, 0, 0);

    // Write to item 25 in the accept cycle is used by that same run.
    v = vecs[0]; v.val = 80; v.pass = 1'b0;
    run(v, "acc_cycle_wr", 1'b1, 25, 1, 13, 22);
    cfg_write(25, 30, 13, 22);
    // Out-of-range index must not alias onto a real item.
    cfg_write(31, 31, 31, 31);

    // Writes during ACCUM and DONE are dropped; DONE holds with out_ready low.
    start(vecs[0], "hold", 1'b0, 0, 0, 0, 0);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_idx = 3; cfg_value = 1; cfg_weight = 31; cfg_volume = 31;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    wait_done(2, cyc);
    check("hold_latency", 64'(cyc), 64'(26));
    hold_exp = {1'b1, 1'b0, 1'b1, 1'b0, 12'd109, 12'd37, 12'd59};
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        cfg_we = 1'b1; cfg_idx = 10; cfg_value = 1; cfg_weight = 31; cfg_volume = 31;
      end
      @(posedge clk); #1;
      cfg_we = 1'b0;
      check($sformatf("hold_stable_%0d", i),
            64'({out_valid, in_ready, out_pass, out_early, out_value, out_weight, out_volume}),
            64'(hold_exp));
    end
    release_result("hold");
    run(vecs[0], "after_drop", 1'b0, 0, 0, 0, 0);

    // Saturation on the narrow instance: 31+31+31 clamps to 63.
    for (int i = 0; i < SN; i++) begin
      @(negedge clk);
      s_cfg_we = 1'b1; s_cfg_idx = SIW'(i);
      s_cfg_value = (i < 3) ? 5'd31 : 5'd0; s_cfg_weight = 0; s_cfg_volume = 0;
      @(posedge clk); #1;
      s_cfg_we = 1'b0;
    end
    @(negedge clk);
    s_in_sel = 4'b0111; s_min_value = 63; s_max_weight = 63; s_max_volume = 63;
    s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    cyc = 0;
    while (!s_out_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("sat_latency", 64'(cyc), 64'(4));
    check("sat_value", 64'(s_out_value), 64'(63));
    check("sat_wt_vol", 64'({s_out_weight, s_out_volume}), 64'(0));
    check("sat_flags", 64'({s_out_pass, s_out_early}), 64'(2'b10));
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;

    // Reset on the fifth ACCUM cycle wipes the run and the table.
    start(vecs[0], "midrst", 1'b0, 0, 0, 0, 0);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_handshake", 64'({in_ready, out_valid}), 64'(2'b10));
    check("midrst_totals", 64'({out_value, out_weight, out_volume}), 64'(0));
    v = '{SEL_DKSZ, 0, 100, 100, 26, 0, 0, 0, 1'b1, 1'b0};
    run(v, "zero_tab_min0", 1'b0, 0, 0, 0, 0);
    v.minv = 1; v.pass = 1'b0;
    run(v, "zero_tab_min1", 1'b0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/knap_eval_seq.md
Name: knap_eval_seq

Overview:
Sequential, parametrised successor to the team's combinational knapsack validity checker. Coefficients live in a writable per-item table rather than constants. Item selections are accepted over a valid/ready handshake and accumulated one item per cycle. The block returns value, weight and volume totals, a pass/fail verdict against run-time thresholds, and exits early once a capacity limit is exceeded. It sits between the selection generator and the solution collector in the knapsack search datapath.

Parameters:
N_ITEMS, 26, number of items (selection vector width); must be >= 2
COEF_W, 5, width of each per-item value/weight/volume coefficient
ACC_W, 12, width of total accumulators and thresholds
IDX_W, 5, width of item index; must satisfy 2^IDX_W >= N_ITEMS

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
cfg_we  in  1  coefficient table write strobe
cfg_idx  in  IDX_W  item index to write
cfg_value  in  COEF_W  value coefficient
cfg_weight  in  COEF_W  weight coefficient
cfg_volume  in  COEF_W  volume coefficient
min_value  in  ACC_W  pass threshold, sampled on accept
max_weight  in  ACC_W  weight limit, sampled on accept
max_volume  in  ACC_W  volume limit, sampled on accept
in_valid  in  1  selection offered
in_ready  out  1  block can accept a selection
in_sel  in  N_ITEMS  bit i set = item i selected
out_valid  out  1  result available
out_ready  in  1  collector accepts result
out_pass  out  1  value>=min && weight<=max_weight && volume<=max_volume
out_early  out  1  run aborted on a capacity overflow
out_value  out  ACC_W  total value
out_weight  out  ACC_W  total weight
out_volume  out  ACC_W  total volume

Behaviour:
- Reset: state=IDLE; idx=0; accumulators, latched thresholds and latched selection = 0; all coefficient table entries = 0; in_ready=1; out_valid=0; out_early=0; out_pass=0.
- FSM states: IDLE, ACCUM, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_sel and the three thresholds, clear accumulators and out_early, set idx=0, go to ACCUM.
- ACCUM: in_ready=0. Each cycle, if sel[idx] is set, add the three coefficients of item idx to the accumulators. Every add saturates at 2^ACC_W-1; no wrap.
  - If the post-add weight exceeds max_weight or the post-add volume exceeds max_volume: set out_early=1 and go to DONE.
  - Else if idx==N_ITEMS-1: go to DONE.
  - Else: idx+1.
- Latency: out_valid rises N_ITEMS cycles after the accept cycle on a full pass. On early exit after item k, it rises k+1 cycles after the accept cycle.
- DONE: out_valid=1. Totals and out_early are held stable. out_pass is a function of the registered totals and latched thresholds, so it is also stable.
  - out_valid&&out_ready returns the FSM to IDLE the next cycle. There is no same-cycle re-accept, so the minimum issue interval is N_ITEMS+2 cycles.
  - If out_ready stays low, the result holds indefinitely.
- Coefficient writes: applied only when state==IDLE and cfg_idx<N_ITEMS; otherwise silently dropped.
  - A write in the same cycle as an accept takes effect for that run, because item 0 is first read in the next cycle.
- Thresholds and in_sel changing after accept have no effect on the run in progress.
- rst asserted in any state, including mid-ACCUM or DONE, forces the reset values on the next edge. Coefficient table is cleared too.
- in_valid while in_ready=0 is ignored; upstream must hold it until accepted.

Test Plan:
- Load items 0..25 with (value,weight,volume) = A(4,28,27) … Z(30,13,22); select items 3,10,18,25 (D,K,S,Z); min=100, max=100/100 -> out_valid 26 cycles after accept; value=109, weight=37, volume=59, pass=1, early=0.
- Same table; select items 0,2,4,5 (weights 28,27,27,28); max_weight=100 -> abort after item 5; out_valid 6 cycles after accept; weight=110, early=1, pass=0.
- Same table; select D,K,S,Z; min=180 -> totals as in the first scenario; pass=0, early=0 (value shortfall only).
- ACC_W=6, max thresholds=63; three items of value 31, weight 0, volume 0 selected -> out_value=63 (saturated, not 29).
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and all outputs stable, in_ready=0; a cfg_we pulse during ACCUM or DONE is not applied (verified on the next run).
- Assert rst on cycle 5 of ACCUM -> next cycle in_ready=1, out_valid=0, totals 0; a subsequent run reads all-zero coefficients (value=0, pass only if min=0).
